aes_128_key_sched: RTL and testbench
====================================

AES_128_KEY_SCHED -- requirements
Module: aes_128_key_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: kill  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key_in  input  128  cipher key; byte 0 = key_in[127:120] (FIPS-197 order).
REQ-004 SHALL have port: key_load  input  1  one-cycle strobe; starts expansion of key_in.
REQ-005 SHALL have port: key_ready  input  1  one-cycle pulse from the core; the current key_round has been consumed.
REQ-006 SHALL have port: restart  input  1  one-cycle strobe; rewinds the round index to 0 for a new block.
REQ-007 SHALL have port: key_round  output  128  round key currently presented to the core.
REQ-008 SHALL have port: key_valid  output  1  high while the expanded schedule is complete and served.
REQ-009 SHALL have port: busy  output  1  high during expansion.
REQ-010 SHALL have port: key_req_err_irq_pulse  output  1  one-cycle pulse on an illegal key_ready.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND and READY, with IDLE after reset.
REQ-012 SHALL, on any edge with key_load=1 (any state): store key_in as rk0, set rnd=1, enter EXPAND, and deassert key_valid.
REQ-013 SHALL, in EXPAND, compute one round key per cycle: rk[rnd] from rk[rnd-1] via RotWord, SubWord (4 S-boxes), Rcon[rnd], and a word XOR chain; then rnd increments.
REQ-014 SHALL use Rcon = 01,02,04,08,10,20,40,80,1B,36 for rnd 1..10.
REQ-015 SHALL hold rk0..rk10 in an 11x128 register array.
REQ-016 SHALL, on the edge writing rk10 (10th edge after the key_load edge), enter READY, set key_valid=1, busy=0 and idx=0.
REQ-017 SHALL drive busy=1 exactly while in EXPAND.
REQ-018 SHALL drive key_round = rk[idx] registered in READY; key_round SHALL be 128'h0 in IDLE and EXPAND.
REQ-019 SHALL, in READY with key_ready=1, advance idx by 1 on that edge; when idx=10, idx SHALL wrap to 0.
REQ-020 SHALL reflect the new idx on key_round on the cycle after the key_ready edge, i.e. 1-cycle latency.
REQ-021 SHALL, on restart=1 in READY, set idx=0; restart SHALL have priority over a simultaneous key_ready.
REQ-022 SHALL treat restart outside READY as a no-op.
REQ-023 SHALL, on key_ready=1 while not in READY, ignore the request and pulse key_req_err_irq_pulse high for exactly 1 cycle.
REQ-024 SHALL give key_load priority over both key_ready and restart on the same edge; no error pulse is raised for a key_ready on that edge.
REQ-025 SHALL, on key_load during EXPAND, abort the current expansion and restart from the new key; no partial schedule is ever marked valid.

Reset
REQ-026 SHALL, while kill=1 (asynchronously), force state=IDLE, rnd=0, idx=0, key_round=0, key_valid=0, busy=0 and key_req_err_irq_pulse=0.
REQ-027 SHALL leave the contents of the rk array unspecified after reset; outputs SHALL not depend on them until the next READY.
REQ-028 SHALL, on kill asserted mid-EXPAND or mid-READY, discard the schedule; a new key_load is required.

Verification
REQ-029 SHALL pass this scenario: key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy high for 10 cycles; key_valid rises 10 cycles after the load edge; key_round=2b7e1516...4f3c.
REQ-030 SHALL pass this scenario: continuing from REQ-029, 1 key_ready pulse -> key_round=a0fafe1788542cb123a339392a6c7605; 10 pulses total -> d014f9a8c9ee2589e13f0cc8b6630ca6; an 11th pulse wraps -> rk0.
REQ-031 SHALL pass this scenario: key_ready during EXPAND -> key_req_err_irq_pulse high for 1 cycle; idx and the expansion are unaffected; key_valid timing is unchanged.
REQ-032 SHALL pass this scenario: restart and key_ready asserted together at idx=5 -> idx=0 and key_round=rk0 on the next cycle.
REQ-033 SHALL pass this scenario: key_load of key 000...0 at rnd=6 of a prior expansion -> key_valid rises 10 cycles after the second load, and rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 SHALL pass this scenario: kill pulsed mid-READY -> all outputs are 0 immediately (asynchronously), and key_ready afterwards produces an error pulse.

Source files
------------

// File: rtl/aes_128_key_sched.sv
// AES-128 key schedule: expands a cipher key into rk0..rk10, one round key
// per clock, then serves the round keys to the cipher core in order.
//
// state  | meaning
// IDLE   | no valid schedule, waiting for key_load
// EXPAND | computing rk1..rk10, one round key per cycle
// READY  | schedule complete, key_round = rk[idx]
module aes_128_key_sched (
  input  logic         clk,
  input  logic         kill,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         key_ready,
  input  logic         restart,
  output logic [127:0] key_round,
  output logic         key_valid,
  output logic         busy,
  output logic         key_req_err_irq_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_RND = 4'd10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[base -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] key_round_q, key_round_d;
  logic         err_q, err_d;

  // Round key storage; deliberately not reset, a fresh key_load rewrites it.
  logic [127:0] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [127:0] rk_wdata;

  logic [3:0]   prev_idx;
  logic [127:0] rk_prev;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   nxt_idx;

  // One round of the expansion: rk[rnd] from rk[rnd-1].
  always_comb begin
    prev_idx = (rnd_q == 4'd0 || rnd_q > LAST_RND) ? 4'd0 : rnd_q - 4'd1;
    rk_prev  = rk_q[prev_idx];
    rot_w    = {rk_prev[23:0], rk_prev[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    temp_w   = sub_w ^ {rcon(rnd_q), 24'h0};
    n0       = rk_prev[127:96] ^ temp_w;
    n1       = rk_prev[95:64]  ^ n0;
    n2       = rk_prev[63:32]  ^ n1;
    n3       = rk_prev[31:0]   ^ n2;
  end

  // Next-state logic; key_load overrides everything, including the error pulse.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    idx_d       = idx_q;
    key_round_d = key_round_q;
    err_d       = 1'b0;
    rk_we       = 1'b0;
    rk_waddr    = rnd_q;
    rk_wdata    = {n0, n1, n2, n3};
    nxt_idx     = (idx_q >= LAST_RND) ? 4'd0 : idx_q + 4'd1;

    if (key_load) begin
      state_d     = EXPAND;
      rnd_d       = 4'd1;
      idx_d       = 4'd0;
      key_round_d = '0;
      rk_we       = 1'b1;
      rk_waddr    = 4'd0;
      rk_wdata    = key_in;
    end else begin
      if (key_ready && state_q != READY) err_d = 1'b1;
      case (state_q)
        IDLE: ;
        EXPAND: begin
          rk_we = 1'b1;
          if (rnd_q == LAST_RND) begin
            state_d     = READY;
            idx_d       = 4'd0;
            key_round_d = rk_q[0];
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        READY: begin
          if (restart) begin
            idx_d       = 4'd0;
            key_round_d = rk_q[0];
          end else if (key_ready) begin
            idx_d       = nxt_idx;
            key_round_d = rk_q[nxt_idx];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers, cleared asynchronously by kill.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      idx_q       <= 4'd0;
      key_round_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      key_round_q <= key_round_d;
      err_q       <= err_d;
    end
  end

  // Round key array write port.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_waddr] <= rk_wdata;
  end

  assign key_round             = key_round_q;
  assign key_valid             = (state_q == READY);
  assign busy                  = (state_q == EXPAND);
  assign key_req_err_irq_pulse = err_q;

endmodule

// File: tb/tb_aes_128_key_sched.sv
// Bench for aes_128_key_sched: directed scenarios plus a cycle-level model
// that derives the full schedule from GF(2^8) arithmetic.
module tb_aes_128_key_sched;

  logic         clk = 1'b0;
  logic         kill;
  logic [127:0] key_in;
  logic         key_load, key_ready, restart;
  logic [127:0] key_round;
  logic         key_valid, busy, key_req_err_irq_pulse;

  aes_128_key_sched dut (
    .clk                  (clk),
    .kill                 (kill),
    .key_in               (key_in),
    .key_load             (key_load),
    .key_ready            (key_ready),
    .restart              (restart),
    .key_round            (key_round),
    .key_valid            (key_valid),
    .busy                 (busy),
    .key_req_err_irq_pulse(key_req_err_irq_pulse)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  int load_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse (a^254).
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    s = r ^ 8'h63;
    for (int k = 1; k <= 4; k++) s = s ^ ((r << k) | (r >> (8 - k)));
    return s;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- cycle-level model ----------------
  typedef enum {M_IDLE, M_EXP, M_RDY} mode_t;
  mode_t        mode_m = M_IDLE;
  int           cnt_m = 0;
  int           idx_m = 0;
  logic         err_m = 1'b0;
  logic [127:0] key_m = '0;

  always @(posedge clk) cyc_cnt++;

  // Model update on each edge from the inputs the DUT sees.
  always @(posedge clk or posedge kill) begin
    if (kill) begin
      mode_m = M_IDLE;
      cnt_m  = 0;
      idx_m  = 0;
      err_m  = 1'b0;
    end else begin
      err_m = 1'b0;
      if (key_load) begin
        key_m  = key_in;
        mode_m = M_EXP;
        cnt_m  = 10;
        idx_m  = 0;
      end else begin
        if (key_ready && mode_m != M_RDY) err_m = 1'b1;
        if (mode_m == M_EXP) begin
          cnt_m--;
          if (cnt_m == 0) begin
            mode_m = M_RDY;
            idx_m  = 0;
          end
        end else if (mode_m == M_RDY) begin
          if (restart) idx_m = 0;
          else if (key_ready) idx_m = (idx_m + 1) % 11;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [127:0] exp_round;
    exp_round = (mode_m == M_RDY) ? round_key(key_m, idx_m) : 128'h0;
    chk("cyc_key_round", key_round, exp_round);
    chk("cyc_key_valid", 128'(key_valid), 128'(mode_m == M_RDY));
    chk("cyc_busy", 128'(busy), 128'(mode_m == M_EXP));
    chk("cyc_err_irq", 128'(key_req_err_irq_pulse), 128'(err_m));
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [127:0] k, input logic with_ready);
    @(negedge clk);
    key_in    = k;
    key_load  = 1'b1;
    key_ready = with_ready;
    @(negedge clk);
    key_load  = 1'b0;
    key_ready = 1'b0;
    load_cyc  = cyc_cnt;
  endtask

  task automatic pulse_ready(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
    end
  endtask

  task automatic wait_valid(input string nm, input int exp_busy);
    int busy_n = 0;
    for (int i = 0; i < 20 && !key_valid; i++) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 128'(cyc_cnt - load_cyc), 128'd10);
    chk({nm, "_busy_cycles"}, 128'(busy_n), 128'(exp_busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kill      = 1'b1;
    key_in    = '0;
    key_load  = 1'b0;
    key_ready = 1'b0;
    restart   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_round", key_round, 128'h0);
    chk("rst_key_valid", 128'(key_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(key_req_err_irq_pulse), 128'd0);

    chk("model_rk1", round_key(KEY_A, 1), A_RK1);
    chk("model_rk10", round_key(KEY_A, 10), A_RK10);
    chk("model_zero_rk10", round_key(128'h0, 10), Z_RK10);

    @(negedge clk);
    kill = 1'b0;

    // Basic expansion and round key walk with wrap.
    do_load(KEY_A, 1'b0);
    wait_valid("a", 10);
    chk("a_rk0", key_round, KEY_A);
    pulse_ready(1);
    chk("a_rk1", key_round, A_RK1);
    pulse_ready(9);
    chk("a_rk10", key_round, A_RK10);
    pulse_ready(1);
    chk("a_wrap_rk0", key_round, KEY_A);

    // restart beats a simultaneous key_ready.
    pulse_ready(5);
    @(negedge clk);
    key_ready = 1'b1;
    restart   = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    restart   = 1'b0;
    chk("restart_prio_rk0", key_round, KEY_A);
    pulse_ready(1);
    chk("restart_then_rk1", key_round, A_RK1);

    // key_ready during expansion: one error pulse, no timing change.
    do_load(KEY_A, 1'b0);
    @(negedge clk);
    key_ready = 1'b1;
    restart   = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    restart   = 1'b0;
    chk("err_pulse_hi", 128'(key_req_err_irq_pulse), 128'd1);
    @(negedge clk);
    chk("err_pulse_lo", 128'(key_req_err_irq_pulse), 128'd0);
    wait_valid("err", 7);
    chk("err_rk0", key_round, KEY_A);

    // Abort at rnd=6 with a zero key; key_ready on the load edge is swallowed.
    do_load(KEY_A, 1'b0);
    repeat (4) @(negedge clk);
    do_load(128'h0, 1'b1);
    wait_valid("zero", 10);
    chk("zero_rk0", key_round, 128'h0);
    pulse_ready(10);
    chk("zero_rk10", key_round, Z_RK10);

    // Asynchronous kill mid-READY.
    pulse_ready(3);
    @(posedge clk);
    #2 kill = 1'b1;
    #1;
    chk("kill_key_round", key_round, 128'h0);
    chk("kill_key_valid", 128'(key_valid), 128'd0);
    chk("kill_busy", 128'(busy), 128'd0);
    chk("kill_err", 128'(key_req_err_irq_pulse), 128'd0);
    @(negedge clk);
    kill = 1'b0;
    pulse_ready(1);
    chk("post_kill_err", 128'(key_req_err_irq_pulse), 128'd1);
    chk("post_kill_valid", 128'(key_valid), 128'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
